dht11_uart_reporter: RTL and testbench
======================================

Name: dht11_uart_reporter

Overview:
Downstream consumer of the DHT11 reader. On each completed sensor read, it latches the four measurement bytes and the error flag. It then serialises them as a fixed 7-byte framed packet on a UART TX line for the host. It runs in the 100 MHz PLL clock domain alongside the DHT11 reader.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 2
HEADER_BYTE, 8'hAA, first byte of every frame

Ports:
clk  input  1  system clock (100 MHz from PLL)
reset  input  1  synchronous, active-high reset
sample_valid  input  1  one-cycle pulse: a DHT11 read has completed; data inputs are stable this cycle
hum_int  input  8  humidity integer byte
hum_float  input  8  humidity fractional byte
temp_int  input  8  temperature integer byte
temp_float  input  8  temperature fractional byte
error  input  1  DHT11 read/parity error for this sample
tx  output  1  UART transmit line, idle high
busy  output  1  high while a frame is being transmitted
frame_done  output  1  one-cycle pulse after the last stop bit of a frame

Behaviour:
- Reset values (synchronous, active-high): tx=1, busy=0, frame_done=0, state=IDLE, overrun flag=0, all counters=0.
- Frame order: HEADER_BYTE, STATUS, hum_int, hum_float, temp_int, temp_float, CHECKSUM.
- STATUS: bit0=error, bit1=overrun, bits7..2=0.
- CHECKSUM: (hum_int+hum_float+temp_int+temp_float) mod 256, using the latched values. The 8-bit truncation matches the DHT11 parity rule.
- UART byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles. Bytes are sent back-to-back with no idle gap.
- Full frame length: 70*CLKS_PER_BIT cycles.
- Acceptance: sample_valid is accepted only when state==IDLE at that clock edge.
  - On acceptance: latch all data inputs and error, snapshot the overrun flag into STATUS, clear the overrun flag, set busy=1.
  - tx drives the header start bit beginning the next cycle (1-cycle latency).
- Drop rule: sample_valid while state!=IDLE is dropped. The latched data is unchanged and the overrun flag is set; it is reported in the next accepted frame.
- FSM states:
  - IDLE: tx=1. Exits to LOAD on an accepted sample_valid.
  - LOAD: selects the byte at the current index. Loads the shift register; bit counter=0.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0]; shifts after each bit; 8 bits.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index<6, increment and go to LOAD. Otherwise go to DONE.
  - DONE: single cycle. frame_done=1, busy=0, returns to IDLE.
  - LOAD consumes zero bit time: the shift register loads on the same edge START begins, so START is still exactly CLKS_PER_BIT cycles.
- Sample during DONE is dropped and counts as overrun. It is accepted only from the cycle after DONE.
- busy is registered. It rises the cycle after acceptance and falls in the cycle frame_done is high.
- Reset mid-frame: takes effect the next edge. tx=1 immediately, busy=0, overrun cleared, no frame_done, partial frame abandoned.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. It is 16 bits wide.

Decomposition:
- Package dht11_pkg: HEADER_BYTE default, FRAME_BYTES=7, STATUS_ERR_BIT=0, STATUS_OVR_BIT=1, FSM state enum.
- One sub-module, uart_tx_byte, handles the START/DATA/STOP bit timing.
  - Inputs: byte plus a start pulse. Outputs: tx and a byte_done pulse.
  - The reporter FSM sequences the 7 bytes and builds STATUS/CHECKSUM.

Test Plan:
- CLKS_PER_BIT=4. Reset, then sample_valid with hum=0x37/0x00, temp=0x18/0x03, error=0.
  - Decoded bytes: AA 00 37 00 18 03 52.
  - frame_done exactly 280 cycles after tx first falls; busy high throughout.
- Checksum wrap: inputs 0xFF, 0xFF, 0x01, 0x02, error=1 -> STATUS=0x01, CHECKSUM=0x01.
- Overrun:
  - A second sample_valid 50 cycles into frame 1 is dropped; frame 1 bytes are unchanged.
  - A third sample after frame_done gives STATUS=0x02 (plus error bit as given).
  - A fourth frame gives STATUS=0x00.
- Boundary:
  - sample_valid in the DONE cycle -> dropped, overrun set.
  - sample_valid on the cycle after DONE -> accepted; tx low one cycle later.
- Reset at cycle 100 of a frame -> tx=1 and busy=0 the next cycle; no frame_done. The next sample produces a clean frame with STATUS=0x00.
- Bit timing: with CLKS_PER_BIT=868, every tx transition lands on a multiple of 868 cycles from the first falling edge.

Source files
------------

// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared constants, state types and frame byte selection for the DHT11 UART reporter
package dht11_pkg;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hAA;
  localparam int         FRAME_BYTES     = 7;
  localparam int         STATUS_ERR_BIT  = 0;
  localparam int         STATUS_OVR_BIT  = 1;

  // Reporter frame sequencing states
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  // Per-byte bit timing states inside uart_tx_byte
  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  // Byte at position idx of the frame; checksum is the 8-bit sum of the payload
  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic [7:0] hdr,
    input logic [7:0] status,
    input logic [7:0] h_i,
    input logic [7:0] h_f,
    input logic [7:0] t_i,
    input logic [7:0] t_f
  );
    logic [7:0] sum;
    sum = h_i + h_f + t_i + t_f;
    case (idx)
      3'd0:    return hdr;
      3'd1:    return status;
      3'd2:    return h_i;
      3'd3:    return h_f;
      3'd4:    return t_i;
      3'd5:    return t_f;
      default: return sum;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART byte transmitter with back-to-back restart
// Ports: clk, reset (sync, active-high); start + data load a byte (accepted when idle
// or in the byte_done cycle); tx is the registered line; byte_done marks the last
// cycle of the stop bit.
module uart_tx_byte
  import dht11_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  bit_state_t  state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        tx_q, tx_n;
  logic        bit_last;

  assign bit_last  = (baud_cnt == 16'(CLKS_PER_BIT - 1));
  assign byte_done = (state == B_STOP) && bit_last;
  assign tx        = tx_q;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = tx_q;
    case (state)
      B_START: begin
        if (bit_last) begin
          baud_cnt_n = '0;
          state_n    = B_DATA;
          tx_n       = shift[0];
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      B_DATA: begin
        if (bit_last) begin
          baud_cnt_n = '0;
          shift_n    = shift >> 1;
          if (bit_cnt == 3'd7) begin
            state_n = B_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      B_STOP: begin
        if (bit_last) begin
          baud_cnt_n = '0;
          state_n    = B_IDLE;
          tx_n       = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      default: begin
        tx_n = 1'b1;
      end
    endcase
    // A start in the final stop cycle chains the next byte with no idle gap
    if (start) begin
      state_n    = B_START;
      baud_cnt_n = '0;
      bit_cnt_n  = '0;
      shift_n    = data;
      tx_n       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= B_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

endmodule

// File: rtl/dht11_uart_reporter.sv
// rtl/dht11_uart_reporter.sv - latches DHT11 samples and sends them as a 7-byte UART frame
// Ports: clk, reset (sync, active-high); sample_valid pulse with hum_int, hum_float,
// temp_int, temp_float, error; tx UART line (idle high); busy during a frame;
// frame_done one-cycle pulse after the last stop bit.
module dht11_uart_reporter
  import dht11_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic       error,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  state_t     state, state_n;
  logic [2:0] idx, idx_n, sel_idx;
  logic [7:0] h_i_q, h_f_q, t_i_q, t_f_q, status_q, status_new;
  logic       overrun, overrun_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic       latch;
  logic       byte_start;
  logic       byte_done;
  logic [7:0] byte_data;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    sel_idx    = idx;
    overrun_n  = overrun;
    busy_n     = busy_q;
    done_n     = 1'b0;
    latch      = 1'b0;
    byte_start = 1'b0;
    status_new = '0;
    status_new[STATUS_ERR_BIT] = error;
    status_new[STATUS_OVR_BIT] = overrun;
    case (state)
      S_IDLE: begin
        if (sample_valid) begin
          latch     = 1'b1;
          overrun_n = 1'b0;
          busy_n    = 1'b1;
          idx_n     = '0;
          state_n   = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_start = 1'b1;
        state_n    = S_SEND;
      end
      S_SEND: begin
        // Next byte is loaded in the last stop cycle so LOAD costs no bit time
        if (byte_done) begin
          if (idx != 3'(FRAME_BYTES - 1)) begin
            idx_n      = idx + 3'd1;
            sel_idx    = idx + 3'd1;
            byte_start = 1'b1;
          end else begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (sample_valid && (state != S_IDLE)) begin
      overrun_n = 1'b1;
    end
  end

  assign byte_data = frame_byte(sel_idx, HEADER_BYTE, status_q, h_i_q, h_f_q, t_i_q, t_f_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      overrun  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      h_i_q    <= '0;
      h_f_q    <= '0;
      t_i_q    <= '0;
      t_f_q    <= '0;
      status_q <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      overrun <= overrun_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      if (latch) begin
        h_i_q    <= hum_int;
        h_f_q    <= hum_float;
        t_i_q    <= temp_int;
        t_f_q    <= temp_float;
        status_q <= status_new;
      end
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (byte_start),
    .data     (byte_data),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// tb/tb_dht11_uart_reporter.sv - self-checking bench for dht11_uart_reporter
module tb_dht11_uart_reporter;

  localparam int C  = 4;
  localparam int CS = 868;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset;
  logic       sv, err;
  logic [7:0] hi, hf, ti, tf;
  logic       tx, busy, fd;
  logic       s_sv, s_err;
  logic [7:0] s_hi, s_hf, s_ti, s_tf;
  logic       s_tx, s_busy, s_fd;

  dht11_uart_reporter #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .sample_valid(sv),
    .hum_int(hi), .hum_float(hf), .temp_int(ti), .temp_float(tf), .error(err),
    .tx(tx), .busy(busy), .frame_done(fd)
  );

  dht11_uart_reporter #(.CLKS_PER_BIT(CS)) dut_slow (
    .clk(clk), .reset(reset), .sample_valid(s_sv),
    .hum_int(s_hi), .hum_float(s_hf), .temp_int(s_ti), .temp_float(s_tf), .error(s_err),
    .tx(s_tx), .busy(s_busy), .frame_done(s_fd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic e);
    @(negedge clk);
    hi = a; hf = b; ti = c; tf = d; err = e; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge; samples each bit mid-cell
  task automatic decode(input string tag, input logic [55:0] exp);
    logic [69:0] bits;
    logic [7:0]  got;
    int kpos, target, ferr, busy_low, fd_early;
    chk({tag, " load tx"}, tx, 1);
    chk({tag, " load busy"}, busy, 1);
    @(negedge clk);
    chk({tag, " start latency"}, tx, 0);
    kpos = 0; ferr = 0; busy_low = 0; fd_early = 0;
    for (int n = 0; n < 70; n++) begin
      target = n * C + C / 2;
      repeat (target - kpos) @(negedge clk);
      kpos = target;
      bits[n] = tx;
      if (busy !== 1'b1) busy_low++;
      if (fd !== 1'b0) fd_early++;
    end
    repeat (70 * C - 1 - kpos) @(negedge clk);
    chk({tag, " fd before 70 bits"}, fd, 0);
    chk({tag, " busy last cycle"}, busy, 1);
    @(negedge clk);
    chk({tag, " fd at 70 bits"}, fd, 1);
    chk({tag, " busy in done"}, busy, 0);
    chk({tag, " tx in done"}, tx, 1);
    for (int j = 0; j < 7; j++) begin
      if (bits[j * 10] !== 1'b0) ferr++;
      if (bits[j * 10 + 9] !== 1'b1) ferr++;
      for (int i = 0; i < 8; i++) got[i] = bits[j * 10 + 1 + i];
      chk($sformatf("%s byte%0d", tag, j), got, exp[55 - 8 * j -: 8]);
    end
    chk({tag, " framing"}, ferr, 0);
    chk({tag, " busy drop"}, busy_low, 0);
    chk({tag, " fd early"}, fd_early, 0);
  endtask

  typedef struct {
    logic [7:0] h, hf, t, tf;
    logic       e;
    logic [7:0] st, ck;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [55:0] sframe;
    logic [7:0]  b;
    logic        prev, bitv;
    int          exp_tr, ntrans, viol, f0, fd_at, fd_seen, tx_low;

    vt[0] = '{8'h37, 8'h00, 8'h18, 8'h03, 1'b0, 8'h00, 8'h52};
    vt[1] = '{8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1, 8'h01, 8'h01};
    vt[2] = '{8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 8'h00, 8'hA0};
    vt[3] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 8'h01, 8'h00};
    vt[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};

    reset = 1'b1; sv = 1'b0; err = 1'b0; hi = '0; hf = '0; ti = '0; tf = '0;
    s_sv = 1'b0; s_err = 1'b0; s_hi = '0; s_hf = '0; s_ti = '0; s_tf = '0;
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset fd", fd, 0);
    chk("reset slow tx", s_tx, 1);
    chk("reset slow busy", s_busy, 0);
    chk("reset slow fd", s_fd, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      pulse(vt[i].h, vt[i].hf, vt[i].t, vt[i].tf, vt[i].e);
      decode($sformatf("vec%0d", i),
             {8'hAA, vt[i].st, vt[i].h, vt[i].hf, vt[i].t, vt[i].tf, vt[i].ck});
    end

    // Overrun: drop mid-frame, report once, then clear
    pulse(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    fork
      decode("ovr1", {8'hAA, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
      begin
        repeat (50) @(negedge clk);
        pulse(8'h99, 8'h99, 8'h99, 8'h99, 1'b1);
      end
    join
    pulse(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    decode("ovr2", {8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});
    pulse(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
    decode("ovr3", {8'hAA, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A});

    // Sample in DONE is dropped; sample on the following cycle is accepted
    pulse(8'h10, 8'h10, 8'h10, 8'h10, 1'b0);
    decode("bnd0", {8'hAA, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h40});
    hi = 8'hEE; hf = 8'hEE; ti = 8'hEE; tf = 8'hEE; err = 1'b1; sv = 1'b1;
    @(negedge clk);
    chk("bnd idle busy", busy, 0);
    chk("bnd idle fd", fd, 0);
    hi = 8'h0A; hf = 8'h0B; ti = 8'h0C; tf = 8'h0D; err = 1'b0;
    @(negedge clk);
    sv = 1'b0;
    decode("bnd1", {8'hAA, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h2E});
    pulse(8'h01, 8'h01, 8'h01, 8'h01, 1'b0);
    decode("bnd2", {8'hAA, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h04});

    // Reset mid-frame after an overrun was recorded
    pulse(8'h20, 8'h21, 8'h22, 8'h23, 1'b0);
    repeat (50) @(negedge clk);
    pulse(8'h77, 8'h77, 8'h77, 8'h77, 1'b1);
    repeat (48) @(negedge clk);
    chk("pre-reset tx", tx, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset tx", tx, 1);
    chk("mid reset busy", busy, 0);
    chk("mid reset fd", fd, 0);
    reset = 1'b0;
    fd_seen = 0; tx_low = 0;
    repeat (300) begin
      @(negedge clk);
      if (fd !== 1'b0) fd_seen++;
      if (tx !== 1'b1) tx_low++;
    end
    chk("abandoned fd", fd_seen, 0);
    chk("abandoned tx", tx_low, 0);
    pulse(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    decode("rst1", {8'hAA, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});

    // Bit timing at the real baud divisor
    sframe = {8'hAA, 8'h00, 8'h37, 8'h00, 8'h18, 8'h03, 8'h52};
    exp_tr = 0; prev = 1'b1;
    for (int j = 0; j < 7; j++) begin
      b = sframe[55 - 8 * j -: 8];
      for (int n = 0; n < 10; n++) begin
        bitv = (n == 0) ? 1'b0 : (n == 9) ? 1'b1 : b[n - 1];
        if (bitv != prev) exp_tr++;
        prev = bitv;
      end
    end
    @(negedge clk);
    s_hi = 8'h37; s_hf = 8'h00; s_ti = 8'h18; s_tf = 8'h03; s_err = 1'b0; s_sv = 1'b1;
    @(negedge clk);
    s_sv = 1'b0;
    prev = 1'b1; f0 = -1; ntrans = 0; viol = 0; fd_at = -1;
    for (int k = 0; k < 70 * CS + 20; k++) begin
      @(negedge clk);
      if (s_tx !== prev) begin
        if (f0 < 0) f0 = cyc;
        else if (((cyc - f0) % CS) != 0) viol++;
        ntrans++;
        prev = s_tx;
      end
      if (s_fd === 1'b1) begin
        fd_at = cyc;
        break;
      end
    end
    chk("slow off-grid transitions", viol, 0);
    chk("slow transition count", ntrans, exp_tr);
    chk("slow frame length", fd_at - f0, 70 * CS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
